sub_cpu_mailbox_slave: RTL and testbench

- Avalon-MM slave that sits directly downstream of the SUB_CPU subsystem's exported mm_bridge_0 master; the bridge's m0 signals connect straight to this block's avs_* ports.
- Software on the sub-CPU pushes 32-bit messages into an internal FIFO through a small register map.
- The FIFO drains through a valid/ready stream port to the consumer, which is the main CPU-side stream sink.
- Status, control and a push counter are readable over the same slave.

---
 rtl/sub_cpu_mailbox_slave.sv | 173 +++++++++++++++++
 tb/tb_sub_cpu_mailbox_slave.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_cpu_mailbox_slave.sv
// rtl/sub_cpu_mailbox_slave.sv - Avalon-MM mailbox slave: register-pushed FIFO drained by a valid/ready stream
//
// Purpose: the sub-CPU writes 32-bit messages into a FIFO through a four-word
// register map (DATA, STATUS, CTRL, COUNT); the FIFO head is presented on a
// show-ahead valid/ready stream port to the main-CPU-side sink.
//
// Ports:
//   clk_clk, reset_reset_n      clock, asynchronous active-low reset
//   avs_address[ADDR_W-1:0]     byte address, word offset taken from [3:2]
//   avs_read / avs_write        read / write request
//   avs_writedata[31:0]         write data
//   avs_byteenable[3:0]         byte lanes (disabled DATA lanes stored as 0x00)
//   avs_burstcount              always 1, ignored
//   avs_debugaccess             ignored
//   avs_readdata[31:0]          read data, qualified by avs_readdatavalid
//   avs_readdatavalid           one-cycle strobe the cycle after a read
//   avs_waitrequest             stalls a blocking DATA write while the FIFO is full
//   st_data[31:0]               FIFO head word
//   st_valid                    head valid (non-empty and enabled)
//   st_ready                    consumer accepts the head word
module sub_cpu_mailbox_slave #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 10,
  parameter int LVL_W  = 5
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_burstcount,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic [31:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             enable;
  logic             nonblock;
  logic             overflow;
  logic [31:0]      count;

  logic [1:0]  offset;
  logic        empty;
  logic        full;
  logic        data_wr;
  logic        ctrl_wr;
  logic        flush;
  logic        pop;
  logic        push;
  logic        drop;
  logic [31:0] wdata_masked;
  logic [31:0] status;
  logic [31:0] rd_mux;

  // Only offset bits are decoded; the remaining inputs are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{avs_address[ADDR_W-1:4], avs_address[1:0],
                           avs_burstcount, avs_debugaccess};

  assign offset  = avs_address[3:2];
  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign data_wr = avs_write && (offset == 2'd0);
  assign ctrl_wr = avs_write && (offset == 2'd2);
  assign flush   = ctrl_wr && avs_writedata[2];

  assign st_valid = enable && !empty;
  // A flush in the same cycle suppresses the pop so the head is not consumed.
  assign pop      = st_valid && st_ready && !flush;
  // A full FIFO can still accept a word in a cycle where a pop frees its slot.
  assign push     = data_wr && enable && (!full || pop);
  assign drop     = data_wr && enable && nonblock && full && !pop;

  // Combinational so the stall releases in the very cycle a pop frees a slot,
  // and drops at once when reset clears enable/level.
  assign avs_waitrequest = data_wr && enable && !nonblock && full && !pop;

  assign wdata_masked = {{8{avs_byteenable[3]}} & avs_writedata[31:24],
                         {8{avs_byteenable[2]}} & avs_writedata[23:16],
                         {8{avs_byteenable[1]}} & avs_writedata[15:8],
                         {8{avs_byteenable[0]}} & avs_writedata[7:0]};

  // Gated on empty so the stream data reads 0 out of reset and after a flush.
  assign st_data = empty ? '0 : mem[rd_ptr];

  always_comb begin
    status              = '0;
    status[LVL_W-1:0]   = level;
    status[16]          = empty;
    status[17]          = full;
    status[18]          = overflow;
  end

  always_comb begin
    rd_mux = '0;
    case (offset)
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {30'd0, nonblock, enable};
      2'd3:    rd_mux = count;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata_masked;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      level             <= '0;
      enable            <= 1'b1;
      nonblock          <= 1'b0;
      overflow          <= 1'b0;
      count             <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase
      end

      if (push) count <= count + 32'd1;

      if (ctrl_wr) begin
        if (avs_byteenable[0]) begin
          enable   <= avs_writedata[0];
          nonblock <= avs_writedata[1];
        end
        if (avs_writedata[3]) overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end

      // A read colliding with a write is a master error; the write wins and
      // the read gets no response.
      if (avs_read && !avs_write) begin
        avs_readdatavalid <= 1'b1;
        avs_readdata      <= rd_mux;
      end else begin
        avs_readdatavalid <= 1'b0;
        avs_readdata      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sub_cpu_mailbox_slave.sv
// tb/tb_sub_cpu_mailbox_slave.sv - self-checking bench for sub_cpu_mailbox_slave
module tb_sub_cpu_mailbox_slave;
  localparam int DEPTH = 16;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [9:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic        avs_burstcount = 1'b1;
  logic        avs_debugaccess = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready = 1'b0;

  sub_cpu_mailbox_slave #(.DEPTH(16), .ADDR_W(10), .LVL_W(5)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_burstcount(avs_burstcount), .avs_debugaccess(avs_debugaccess),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest), .st_data(st_data),
    .st_valid(st_valid), .st_ready(st_ready)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the FIFO as a queue plus the software-visible registers.
  logic [31:0] q[$];
  bit          m_en;
  bit          m_nb;
  bit          m_ovf;
  logic [31:0] m_count;
  logic [31:0] last_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_en = 1'b1;
    m_nb = 1'b0;
    m_ovf = 1'b0;
    m_count = '0;
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[4:0] = 5'(q.size());
    s[16]  = (q.size() == 0);
    s[17]  = (q.size() == DEPTH);
    s[18]  = m_ovf;
    return s;
  endfunction

  task automatic idle_inputs();
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_address = '0;
    avs_writedata = '0;
    avs_byteenable = '0;
  endtask

  // One clock cycle: called at a falling edge with inputs already driven.
  // Checks stream/stall outputs against the model, advances the model across
  // the rising edge, then checks the read response at the next falling edge.
  task automatic step(output bit acc);
    bit          m_valid, m_full, m_pop, data_wr, ctrl_wr, flush, exp_wait, exp_rdv;
    logic [1:0]  off;
    logic [31:0] exp_rd, masked;
    #1;
    off      = avs_address[3:2];
    m_valid  = m_en && (q.size() != 0);
    m_full   = (q.size() == DEPTH);
    data_wr  = avs_write && (off == 2'd0);
    ctrl_wr  = avs_write && (off == 2'd2);
    flush    = ctrl_wr && avs_writedata[2];
    m_pop    = m_valid && st_ready && !flush;
    exp_wait = data_wr && m_en && !m_nb && m_full && !m_pop;
    chk("st_valid", st_valid, m_valid);
    if (m_valid) chk("st_data", st_data, q[0]);
    chk("waitrequest", avs_waitrequest, exp_wait);
    exp_rdv = avs_read && !avs_write;
    case (off)
      2'd1:    exp_rd = model_status();
      2'd2:    exp_rd = {30'd0, m_nb, m_en};
      2'd3:    exp_rd = m_count;
      default: exp_rd = '0;
    endcase
    for (int b = 0; b < 4; b++)
      masked[8*b +: 8] = avs_byteenable[b] ? avs_writedata[8*b +: 8] : 8'h00;
    if (m_pop) last_pop = st_data;
    @(posedge clk_clk);
    if (flush) q.delete();
    else if (m_pop) void'(q.pop_front());
    if (ctrl_wr) begin
      if (avs_byteenable[0]) begin
        m_en = avs_writedata[0];
        m_nb = avs_writedata[1];
      end
      if (avs_writedata[3]) m_ovf = 1'b0;
    end
    if (data_wr && m_en) begin
      if (!m_full || m_pop) begin
        q.push_back(masked);
        m_count++;
      end else if (m_nb) begin
        m_ovf = 1'b1;
      end
    end
    acc = !exp_wait;
    @(negedge clk_clk);
    chk("readdatavalid", avs_readdatavalid, exp_rdv);
    if (exp_rdv) chk("readdata", avs_readdata, exp_rd);
  endtask

  task automatic idle_step();
    bit acc;
    step(acc);
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be);
    bit acc;
    acc = 1'b0;
    avs_write = 1'b1;
    avs_address = {6'd0, off, 2'b00};
    avs_writedata = d;
    avs_byteenable = be;
    for (int i = 0; i < 64 && !acc; i++) step(acc);
    chk("write_accepted", acc, 1'b1);
    idle_inputs();
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
    bit acc;
    avs_read = 1'b1;
    avs_address = {6'd0, off, 2'b00};
    step(acc);
    d = avs_readdata;
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk_clk);
    reset_reset_n = 1'b0;
    idle_inputs();
    st_ready = 1'b0;
    model_reset();
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  task automatic drain(input int n);
    st_ready = 1'b1;
    for (int i = 0; i < n; i++) idle_step();
    st_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    bit          acc;
    bit          hold;
    int          r;

    model_reset();
    last_pop = '0;
    idle_inputs();

    // Reset state.
    @(negedge clk_clk);
    @(negedge clk_clk);
    chk("rst_st_valid", st_valid, 1'b0);
    chk("rst_st_data", st_data, 32'h0);
    chk("rst_waitrequest", avs_waitrequest, 1'b0);
    chk("rst_readdatavalid", avs_readdatavalid, 1'b0);
    chk("rst_readdata", avs_readdata, 32'h0);
    reset_reset_n = 1'b1;

    // 1: register reads after reset, with an idle cycle checking the strobe drops.
    bus_read(2'd0, rd); chk("t1_data", rd, 32'h0);
    bus_read(2'd1, rd); chk("t1_status", rd, 32'h0001_0000);
    bus_read(2'd2, rd); chk("t1_ctrl", rd, 32'h1);
    bus_read(2'd3, rd); chk("t1_count", rd, 32'h0);
    idle_step();

    // 2: two pushes, then drain in order.
    bus_write(2'd0, 32'hDEADBEEF, 4'hF);
    bus_write(2'd0, 32'h12345678, 4'hF);
    bus_read(2'd1, rd); chk("t2_status", rd, 32'h2);
    bus_read(2'd3, rd); chk("t2_count", rd, 32'h2);
    chk("t2_st_valid", st_valid, 1'b1);
    chk("t2_st_data", st_data, 32'hDEADBEEF);
    st_ready = 1'b1;
    idle_step(); chk("t2_pop0", last_pop, 32'hDEADBEEF);
    idle_step(); chk("t2_pop1", last_pop, 32'h12345678);
    st_ready = 1'b0;
    idle_step();
    chk("t2_st_valid_low", st_valid, 1'b0);
    bus_read(2'd1, rd); chk("t2_status_empty", rd, 32'h0001_0000);

    // 3: blocking write on a full FIFO completes with the freeing pop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) bus_write(2'd0, $urandom, 4'hF);
    avs_write = 1'b1;
    avs_address = '0;
    avs_writedata = 32'hAAAA5555;
    avs_byteenable = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step(acc);
      chk("t3_stalled", acc, 1'b0);
    end
    chk("t3_waitrequest_high", avs_waitrequest, 1'b1);
    st_ready = 1'b1;
    step(acc);
    chk("t3_released", acc, 1'b1);
    idle_inputs();
    st_ready = 1'b0;
    bus_read(2'd1, rd); chk("t3_status_full", rd, 32'h0002_0010);
    bus_read(2'd3, rd); chk("t3_count", rd, 32'd17);
    drain(DEPTH);
    chk("t3_last_word", last_pop, 32'hAAAA5555);
    bus_read(2'd1, rd); chk("t3_status_empty", rd, 32'h0001_0000);

    // 4: non-blocking overflow and its clear.
    do_reset();
    bus_write(2'd2, 32'h3, 4'hF);
    for (int i = 0; i < DEPTH + 2; i++) bus_write(2'd0, $urandom, 4'hF);
    bus_read(2'd3, rd); chk("t4_count", rd, 32'd16);
    bus_read(2'd1, rd); chk("t4_status_ovf", rd, 32'h0006_0010);
    bus_write(2'd2, 32'hB, 4'hF);
    bus_read(2'd1, rd); chk("t4_status_clr", rd, 32'h0002_0010);
    bus_read(2'd2, rd); chk("t4_ctrl", rd, 32'h3);

    // 5: byte-enable masking, then flush racing a ready consumer.
    do_reset();
    last_pop = '0;
    bus_write(2'd0, 32'h11223344, 4'b0101);
    chk("t5_st_data", st_data, 32'h0022_0044);
    st_ready = 1'b1;
    bus_write(2'd2, 32'h4, 4'hF);
    st_ready = 1'b0;
    chk("t5_no_pop", last_pop, 32'h0);
    bus_read(2'd1, rd); chk("t5_status", rd, 32'h0001_0000);
    bus_read(2'd3, rd); chk("t5_count", rd, 32'd1);

    // 6: reset asserted in the middle of a stalled write.
    do_reset();
    for (int i = 0; i < DEPTH; i++) bus_write(2'd0, $urandom, 4'hF);
    avs_write = 1'b1;
    avs_address = '0;
    avs_writedata = 32'hCAFEF00D;
    avs_byteenable = 4'hF;
    step(acc);
    chk("t6_stalled", acc, 1'b0);
    #2;
    reset_reset_n = 1'b0;
    #1;
    chk("t6_waitrequest", avs_waitrequest, 1'b0);
    chk("t6_st_valid", st_valid, 1'b0);
    chk("t6_st_data", st_data, 32'h0);
    chk("t6_readdatavalid", avs_readdatavalid, 1'b0);
    idle_inputs();
    model_reset();
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    bus_read(2'd3, rd); chk("t6_count", rd, 32'h0);
    bus_read(2'd2, rd); chk("t6_ctrl", rd, 32'h1);
    bus_read(2'd1, rd); chk("t6_status", rd, 32'h0001_0000);

    // Randomized traffic checked cycle by cycle against the model.
    do_reset();
    hold = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        idle_inputs();
        r = $urandom_range(0, 9);
        if (r <= 4) begin
          avs_write = 1'b1;
          avs_address = {$urandom_range(0, 63), 4'b0000} | 10'($urandom_range(0, 3));
          avs_writedata = $urandom;
          avs_byteenable = 4'($urandom);
        end else if (r <= 6) begin
          avs_read = 1'b1;
          avs_address = 10'($urandom);
        end else if (r == 7) begin
          avs_write = 1'b1;
          avs_address = 10'h008;
          avs_writedata = {28'd0, 1'($urandom), ($urandom_range(0, 5) == 0),
                           1'($urandom), ($urandom_range(0, 3) != 0)};
          avs_byteenable = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'hF;
        end
      end
      st_ready = ($urandom_range(0, 2) == 0);
      step(acc);
      hold = !acc;
    end
    idle_inputs();
    st_ready = 1'b0;
    idle_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
